// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, runs fixed-latency mult/div operations from E
// and requests a D-stage stall while the unit is occupied.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    input  logic        D_md_use,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pendHi_q, pendHi_d, pendLo_q, pendLo_d;
    logic        pendValid_q, pendValid_d;

    logic        isMult, isMultu, isDiv, isDivu, isMulDiv;
    logic [63:0] prodS, prodU;
    logic [31:0] divNum, divDen, safeDen, uQuot, uRem, quot, rem;
    logic        negQuot, negRem;
    logic [31:0] resHi, resLo;
    logic        resValid;

    assign isMult   = (E_md_op == OP_MULT);
    assign isMultu  = (E_md_op == OP_MULTU);
    assign isDiv    = (E_md_op == OP_DIV);
    assign isDivu   = (E_md_op == OP_DIVU);
    assign isMulDiv = isMult | isMultu | isDiv | isDivu;

    assign busy  = (state_q == S_RUN);
    assign start = isMulDiv && !busy;
    assign stall = D_md_use && (start || busy);
    assign HI    = hi_q;
    assign LO    = lo_q;

    assign prodS = $signed({{32{E_rs_data[31]}}, E_rs_data}) * $signed({{32{E_rt_data[31]}}, E_rt_data});
    assign prodU = {32'd0, E_rs_data} * {32'd0, E_rt_data};

    // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign divNum  = (isDiv && E_rs_data[31]) ? -E_rs_data : E_rs_data;
    assign divDen  = (isDiv && E_rt_data[31]) ? -E_rt_data : E_rt_data;
    assign safeDen = (divDen == 32'd0) ? 32'd1 : divDen;
    assign uQuot   = divNum / safeDen;
    assign uRem    = divNum % safeDen;
    assign negQuot = isDiv && (E_rs_data[31] ^ E_rt_data[31]);
    assign negRem  = isDiv && E_rs_data[31];
    assign quot    = negQuot ? -uQuot : uQuot;
    assign rem     = negRem ? -uRem : uRem;

    always_comb begin
        resHi    = 32'd0;
        resLo    = 32'd0;
        resValid = 1'b1;
        if (isMult) begin
            resHi = prodS[63:32];
            resLo = prodS[31:0];
        end else if (isMultu) begin
            resHi = prodU[63:32];
            resLo = prodU[31:0];
        end else begin
            resHi    = rem;
            resLo    = quot;
            resValid = (E_rt_data != 32'd0);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pendHi_d    = pendHi_q;
        pendLo_d    = pendLo_q;
        pendValid_d = pendValid_q;
        if (state_q == S_RUN) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = S_IDLE;
                if (pendValid_q) begin
                    hi_d = pendHi_q;
                    lo_d = pendLo_q;
                end
            end
        end else if (start) begin
            state_d     = S_RUN;
            cnt_d       = (isMult || isMultu) ? MULT_LOAD : DIV_LOAD;
            pendHi_d    = resHi;
            pendLo_d    = resLo;
            pendValid_d = resValid;
        end else if (E_md_op == OP_MTHI) begin
            hi_d = E_rs_data;
        end else if (E_md_op == OP_MTLO) begin
            lo_d = E_rs_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            pendHi_q    <= 32'd0;
            pendLo_q    <= 32'd0;
            pendValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pendHi_q    <= pendHi_d;
            pendLo_q    <= pendLo_d;
            pendValid_q <= pendValid_d;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: latency, HI/LO results, stall and reset behaviour.
module tb_md_sequencer;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic        clk;
    logic        reset;
    logic [3:0]  E_md_op;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic        D_md_use;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int checkCount;
    int failCount;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_md_op   (E_md_op),
        .E_rs_data (E_rs_data),
        .E_rt_data (E_rt_data),
        .D_md_use  (D_md_use),
        .start     (start),
        .busy      (busy),
        .stall     (stall),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change at the falling edge so the next rising edge sees a stable cycle.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic dmu);
        @(negedge clk);
        E_md_op   = op;
        E_rs_data = a;
        E_rt_data = b;
        D_md_use  = dmu;
        #1;
    endtask

    // Issues an op, then walks its n busy cycles presenting busyOp; HI/LO must hold preHi/preLo throughout.
    task automatic issueAndRun(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int n, input logic dmu,
                               input logic [3:0] busyOp, input logic [31:0] preHi,
                               input logic [31:0] preLo);
        applyStimulus(op, a, b, dmu);
        checkOutput({tag, ".start"}, 32'(start), 32'd1);
        checkOutput({tag, ".busyIssue"}, 32'(busy), 32'd0);
        checkOutput({tag, ".stallIssue"}, 32'(stall), 32'(dmu));
        checkOutput({tag, ".hiIssue"}, HI, preHi);
        checkOutput({tag, ".loIssue"}, LO, preLo);
        for (int i = 1; i <= n; i++) begin
            applyStimulus(busyOp, 32'hDEADBEEF, 32'h0000_0003, dmu);
            checkOutput($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
            checkOutput($sformatf("%s.start%0d", tag, i), 32'(start), 32'd0);
            checkOutput($sformatf("%s.stall%0d", tag, i), 32'(stall), 32'(dmu));
            checkOutput($sformatf("%s.hi%0d", tag, i), HI, preHi);
            checkOutput($sformatf("%s.lo%0d", tag, i), LO, preLo);
        end
    endtask

    task automatic checkIdle(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".stall"}, 32'(stall), 32'd0);
        checkOutput({tag, ".hi"}, HI, expHi);
        checkOutput({tag, ".lo"}, LO, expLo);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        reset      = 1'b1;
        E_md_op    = OP_NONE;
        E_rs_data  = 32'd0;
        E_rt_data  = 32'd0;
        D_md_use   = 1'b1;
        #2;
        checkIdle("reset", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b1);
        checkIdle("postReset", 32'd0, 32'd0);

        // -3 * 5 = -15
        issueAndRun("mult", OP_MULT, 32'hFFFFFFFD, 32'd5, 5, 1'b1, OP_NONE, 32'd0, 32'd0);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b1);
        checkIdle("multDone", 32'hFFFFFFFF, 32'hFFFFFFF1);

        issueAndRun("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 1'b0, OP_MTHI,
                    32'hFFFFFFFF, 32'hFFFFFFF1);
        // Back-to-back: DIV issues in the very cycle MULTU's result first appears.
        issueAndRun("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 1'b1, OP_MULT,
                    32'h00000001, 32'hFFFFFFFE);
        issueAndRun("divu", OP_DIVU, 32'd7, 32'd2, 10, 1'b0, OP_NONE,
                    32'hFFFFFFFF, 32'hFFFFFFFD);

        applyStimulus(OP_MTHI, 32'h11, 32'd0, 1'b0);
        checkIdle("mthiCycle", 32'd1, 32'd3);
        applyStimulus(OP_MTLO, 32'h22, 32'd0, 1'b0);
        checkIdle("mtloCycle", 32'h11, 32'd3);
        applyStimulus(4'd7, 32'h99, 32'd1, 1'b1);
        checkOutput("op7.start", 32'(start), 32'd0);
        checkIdle("op7Cycle", 32'h11, 32'h22);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        checkIdle("op7After", 32'h11, 32'h22);

        issueAndRun("divZero", OP_DIV, 32'd5, 32'd0, 10, 1'b1, OP_NONE, 32'h11, 32'h22);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b1);
        checkIdle("divZeroDone", 32'h11, 32'h22);

        issueAndRun("divOvf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, OP_NONE,
                    32'h11, 32'h22);
        // 7 / -2 = -3 rem 1
        issueAndRun("divNegB", OP_DIV, 32'd7, 32'hFFFFFFFE, 10, 1'b0, OP_NONE,
                    32'h00000000, 32'h80000000);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        checkIdle("divNegBDone", 32'h00000001, 32'hFFFFFFFD);

        // Reset in the middle of a MULT must wipe it before it commits.
        applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b0);
        checkOutput("rstMult.start", 32'(start), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        end
        checkOutput("rstMult.busyT3", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkIdle("rstAsync", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
            checkIdle($sformatf("rstAfter%0d", i), 32'd0, 32'd0);
        end
        applyStimulus(OP_MTLO, 32'h5A, 32'd0, 1'b0);
        checkIdle("mtlo5aCycle", 32'd0, 32'd0);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        checkIdle("mtlo5aDone", 32'd0, 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
